// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler and its decimation strobe.
package fft_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        FILL,
        DRAIN,
        DONE
    } state_e;

    localparam int CFG_W    = 8;
    localparam int SAMPLE_W = 10;
    localparam int TDATA_W  = 32;

    // bit0 = forward transform
    localparam logic [CFG_W-1:0] CFG_FWD = 8'h01;

    function automatic int idx_w(input int n_point);
        return (n_point <= 2) ? 1 : $clog2(n_point);
    endfunction

endpackage

// File: rtl/decim_strobe.sv
// Free-running modulo-DECIM counter producing a one-cycle tick on its last count.
module decim_strobe #(
    parameter int DECIM = 8
) (
    input  logic fft_clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

    logic [7:0] dec_cnt;

    assign tick = !clr && (dec_cnt == DEC_LAST);

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge fft_clk or posedge rst) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (clr || dec_cnt == DEC_LAST) begin
            dec_cnt <= '0;
        end else begin
            dec_cnt <= dec_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/fft_frame_sched.sv
// Per-frame FFT sequencer: config word, decimated AXI-Stream sample feed, output frame
// counting with frame_done pulse and sticky overrun / tlast-mismatch error.
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int               N_POINT  = 4096,
    parameter int               DECIM    = 8,
    parameter logic [CFG_W-1:0] CFG_WORD = CFG_FWD
) (
    input  logic                fft_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cont_mode,
    input  logic [SAMPLE_W-1:0] ad_data,
    output logic [CFG_W-1:0]    cfg_tdata,
    output logic                cfg_tvalid,
    input  logic                cfg_tready,
    output logic [TDATA_W-1:0]  s_tdata,
    output logic                s_tvalid,
    input  logic                s_tready,
    output logic                s_tlast,
    input  logic                m_tvalid,
    input  logic                m_tlast,
    output logic                m_tready,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          frame_cnt,
    output logic                err
);

    localparam int               IDX_W    = idx_w(N_POINT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINT - 1);

    state_e           state, state_nxt;
    logic             dec_clr, tick;
    logic [IDX_W-1:0] in_idx, out_idx, load_idx;
    logic             in_fill, s_hs, last_hs, load, drop;
    logic             out_beat, out_last;

    decim_strobe #(.DECIM(DECIM)) u_decim (
        .fft_clk (fft_clk),
        .rst     (rst),
        .clr     (dec_clr),
        .tick    (tick)
    );

    assign cfg_tdata = CFG_WORD;
    assign m_tready  = 1'b1;

    assign in_fill  = (state == FILL);
    assign s_hs     = s_tvalid && s_tready;
    assign last_hs  = in_fill && s_hs && s_tlast;
    // A tick may refill the slot in the same cycle the pending sample is accepted.
    assign load     = in_fill && tick && (!s_tvalid || s_hs) && !last_hs;
    assign drop     = in_fill && tick && s_tvalid && !s_hs;
    assign load_idx = s_hs ? in_idx + IDX_W'(1) : in_idx;
    assign out_beat = (state == DRAIN) && m_tvalid;
    assign out_last = out_beat && (out_idx == LAST_IDX);

    always_ff @(posedge fft_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        cfg_tvalid = 1'b0;
        frame_done = 1'b0;
        dec_clr    = 1'b1;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = CFG;
            end
            CFG: begin
                cfg_tvalid = 1'b1;
                if (cfg_tready) state_nxt = FILL;
            end
            FILL: begin
                dec_clr = 1'b0;
                if (last_hs) state_nxt = DRAIN;
            end
            DRAIN: begin
                dec_clr = 1'b0;
                if (out_last) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = cont_mode ? FILL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge fft_clk or posedge rst) begin
        if (rst) begin
            in_idx    <= '0;
            out_idx   <= '0;
            s_tdata   <= '0;
            s_tvalid  <= 1'b0;
            s_tlast   <= 1'b0;
            frame_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (state == CFG || state == DONE) begin
                in_idx  <= '0;
                out_idx <= '0;
            end else begin
                if (in_fill && s_hs) in_idx <= in_idx + IDX_W'(1);
                if (out_beat)        out_idx <= out_idx + IDX_W'(1);
            end

            if (load) begin
                s_tdata  <= TDATA_W'(ad_data);
                s_tvalid <= 1'b1;
                s_tlast  <= (load_idx == LAST_IDX);
            end else if (s_hs) begin
                s_tvalid <= 1'b0;
                s_tlast  <= 1'b0;
            end

            // m_tlast must coincide exactly with the counted last beat.
            if (drop || (out_beat && (m_tlast != (out_idx == LAST_IDX)))) begin
                err <= 1'b1;
            end

            if (out_last) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule
